// File: rtl/spike_dec_pkg.sv
// Shared defaults and state encoding for the spike train decoder.
// Rate window, count and ISI widths default to 8 bits.
package spike_dec_pkg;
  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_ISI_W       = 8;

  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};
  localparam logic [DEF_ISI_W-1:0] DEF_ISI_MAX = {DEF_ISI_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dec_state_t;
endpackage

// File: rtl/spike_train_decoder_if.sv
// Result channel from the decoder to the readout logic: rate/ISI pair on valid/ready,
// plus a sticky overrun flag.
interface spike_train_decoder_if
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ISI_W = DEF_ISI_W
);
  logic [CNT_W-1:0] rate_out;
  logic [ISI_W-1:0] isi_out;
  logic             data_valid;
  logic             data_ready;
  logic             overrun;

  modport master (
    output rate_out, isi_out, data_valid, overrun,
    input  data_ready
  );

  modport slave (
    input  rate_out, isi_out, data_valid, overrun,
    output data_ready
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a load takes priority over increment.
// Single-cycle update, reset value set by parameter.
module sat_counter #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         sat
);
  assign sat = (cnt == {W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spike_train_decoder.sv
// Decodes a 1-bit spike line into per-window spike rate and last inter-spike interval.
// Result appears 1 cycle after the window's terminal cycle; an unconsumed result is overwritten and flagged.
module spike_train_decoder
  import spike_dec_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ISI_W       = DEF_ISI_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   spike_in,
  spike_train_decoder_if.master  res
);
  dec_state_t             state, state_nxt;
  logic                   adv;
  logic                   spike_d;
  logic                   evt;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic                   term;
  logic [CNT_W-1:0]       spk_cnt, rate_nxt;
  logic                   spk_sat;
  logic [ISI_W-1:0]       isi_cnt, isi_last, isi_nxt;
  logic                   isi_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        adv = ena;
        if (ena) state_nxt = RUN;
      end
      RUN:     adv = ena;
      default: state_nxt = IDLE;
    endcase
  end

  // spike_d tracks the line even while disabled, so a level held across a pause is not a new edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d <= 1'b0;
    end else begin
      spike_d <= spike_in;
    end
  end

  assign evt = spike_in & ~spike_d & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (adv) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  assign term = adv && (win_cnt == {WINDOW_LOG2{1'b1}});

  sat_counter #(.W(CNT_W), .RST_VAL('0)) u_spk_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (evt),
    .ld     (term),
    .ld_val ({CNT_W{1'b0}}),
    .cnt    (spk_cnt),
    .sat    (spk_sat)
  );

  sat_counter #(.W(ISI_W), .RST_VAL({ISI_W{1'b1}})) u_isi_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (adv & ~isi_sat),
    .ld     (evt),
    .ld_val ({{(ISI_W-1){1'b0}}, 1'b1}),
    .cnt    (isi_cnt),
    .sat    (isi_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_last <= {ISI_W{1'b1}};
    end else if (evt) begin
      isi_last <= isi_cnt;
    end
  end

  // A spike landing on the terminal cycle belongs to the window being closed
  assign rate_nxt = (evt && !spk_sat) ? spk_cnt + 1'b1 : spk_cnt;
  assign isi_nxt  = evt ? isi_cnt : isi_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.rate_out   <= '0;
      res.isi_out    <= '0;
      res.data_valid <= 1'b0;
      res.overrun    <= 1'b0;
    end else if (term) begin
      res.rate_out   <= rate_nxt;
      res.isi_out    <= isi_nxt;
      res.data_valid <= 1'b1;
      if (res.data_valid && !res.data_ready) res.overrun <= 1'b1;
    end else if (res.data_valid && res.data_ready) begin
      res.data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench for spike_train_decoder: window timing, rate/ISI decode, handshake and overrun.
module tb_spike_train_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic spike_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spike_train_decoder_if #(.CNT_W(8), .ISI_W(8)) dif ();

  spike_train_decoder #(.WINDOW_LOG2(8), .CNT_W(8), .ISI_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .res      (dif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    spike_in = 1'b0;
    dif.data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dif.rate_out !== 8'd0) begin errors++; $display("FAIL reset_rate got %0d want 0", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd0) begin errors++; $display("FAIL reset_isi got %0d want 0", dif.isi_out); end
    checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dif.data_valid); end
    checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", dif.overrun); end
  endtask

  task automatic test_idle_window();
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (c == 254) begin
        checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL idle_early_valid got %b want 0", dif.data_valid); end
      end
    end
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got %b want 1", dif.data_valid); end
    checks++; if (dif.rate_out !== 8'd0) begin errors++; $display("FAIL idle_rate got %0d want 0", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd255) begin errors++; $display("FAIL idle_isi got %0d want 255", dif.isi_out); end
    checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL idle_overrun got %b want 0", dif.overrun); end
  endtask

  task automatic test_periodic();
    int w;
    do_reset();
    ena = 1'b1;
    dif.data_ready = 1'b1;
    for (int c = 0; c < 768; c++) begin
      spike_in = ((c % 10) == 5);
      tick();
      w = c / 256;
      if ((c % 256) == 255) begin
        checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL periodic_valid w%0d got %b want 1", w, dif.data_valid); end
        checks++; if (dif.rate_out !== ((w % 2 == 0) ? 8'd26 : 8'd25)) begin errors++; $display("FAIL periodic_rate w%0d got %0d want %0d", w, dif.rate_out, (w % 2 == 0) ? 26 : 25); end
        checks++; if (dif.isi_out !== 8'd10) begin errors++; $display("FAIL periodic_isi w%0d got %0d want 10", w, dif.isi_out); end
      end
      if ((c % 256) == 0 && c > 0) begin
        checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL periodic_consumed w%0d got %b want 0", w, dif.data_valid); end
      end
    end
    checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL periodic_overrun got %b want 0", dif.overrun); end
  endtask

  task automatic test_held_high();
    do_reset();
    ena = 1'b1;
    dif.data_ready = 1'b1;
    for (int c = 0; c < 256; c++) begin
      spike_in = (c >= 20 && c < 70);
      tick();
    end
    checks++; if (dif.rate_out !== 8'd1) begin errors++; $display("FAIL held_rate got %0d want 1", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd255) begin errors++; $display("FAIL held_isi got %0d want 255", dif.isi_out); end
  endtask

  task automatic test_overrun();
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 512; c++) begin
      spike_in = (c == 100 || c == 300 || c == 310);
      tick();
      if (c == 255) begin
        checks++; if (dif.rate_out !== 8'd1) begin errors++; $display("FAIL ovr_first_rate got %0d want 1", dif.rate_out); end
        checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag got %b want 0", dif.overrun); end
      end
    end
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", dif.data_valid); end
    checks++; if (dif.rate_out !== 8'd2) begin errors++; $display("FAIL ovr_rate got %0d want 2", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd10) begin errors++; $display("FAIL ovr_isi got %0d want 10", dif.isi_out); end
    checks++; if (dif.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", dif.overrun); end
    spike_in = 1'b0;
    dif.data_ready = 1'b1;
    tick();
    checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid got %b want 0", dif.data_valid); end
    tick();
    checks++; if (dif.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", dif.overrun); end
  endtask

  task automatic test_ena_gap();
    do_reset();
    dif.data_ready = 1'b1;
    for (int c = 0; c < 356; c++) begin
      ena = !(c >= 100 && c < 200);
      if (c >= 100 && c < 200) spike_in = c[0];
      else spike_in = (c == 50 || c == 200 || c == 260);
      tick();
      if (c == 255 || c == 354) begin
        checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid c%0d got %b want 0", c, dif.data_valid); end
      end
    end
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", dif.data_valid); end
    checks++; if (dif.rate_out !== 8'd2) begin errors++; $display("FAIL gap_rate got %0d want 2", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd110) begin errors++; $display("FAIL gap_isi got %0d want 110", dif.isi_out); end
  endtask

  task automatic test_terminal_edge();
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 512; c++) begin
      spike_in = (c == 400 || c == 511);
      dif.data_ready = (c == 511);
      tick();
      if (c == 255) begin
        checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL term_first_valid got %b want 1", dif.data_valid); end
      end
    end
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL term_valid got %b want 1", dif.data_valid); end
    checks++; if (dif.rate_out !== 8'd2) begin errors++; $display("FAIL term_rate got %0d want 2", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd111) begin errors++; $display("FAIL term_isi got %0d want 111", dif.isi_out); end
    checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL term_overrun got %b want 0", dif.overrun); end
    spike_in = 1'b0;
    dif.data_ready = 1'b1;
    tick();
    checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL term_drain got %b want 0", dif.data_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 600; c++) begin
      spike_in = ((c % 37) == 3);
      tick();
    end
    checks++; if (dif.overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun got %b want 1", dif.overrun); end
    rst_n = 1'b0;
    #2;
    checks++; if (dif.rate_out !== 8'd0) begin errors++; $display("FAIL mid_rate got %0d want 0", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd0) begin errors++; $display("FAIL mid_isi got %0d want 0", dif.isi_out); end
    checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", dif.data_valid); end
    checks++; if (dif.overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", dif.overrun); end
    spike_in = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 256; c++) begin
      tick();
      if (c == 254) begin
        checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL mid_restart_early got %b want 0", dif.data_valid); end
      end
    end
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid got %b want 1", dif.data_valid); end
    checks++; if (dif.rate_out !== 8'd0) begin errors++; $display("FAIL mid_restart_rate got %0d want 0", dif.rate_out); end
    checks++; if (dif.isi_out !== 8'd255) begin errors++; $display("FAIL mid_restart_isi got %0d want 255", dif.isi_out); end
  endtask

  initial begin
    dif.data_ready = 1'b0;
    test_reset();
    test_idle_window();
    test_periodic();
    test_held_high();
    test_overrun();
    test_ena_gap();
    test_terminal_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
